// File: rtl/multisim_stream_arbiter_if.sv
// Stream bundle between the per-CPU multisim sources and the shared sink.
// The master modport is the arbiter side; the slave modport is the sources/sink side.
interface multisim_stream_arbiter_if #(
  parameter int N_SRC  = 4,
  parameter int DATA_W = 64,
  parameter int SRC_W  = $clog2(N_SRC)
);
  logic [N_SRC-1:0]        src_vld;
  logic [N_SRC*DATA_W-1:0] src_data;
  logic [N_SRC-1:0]        src_rdy;
  logic                    out_vld;
  logic [DATA_W-1:0]       out_data;
  logic [SRC_W-1:0]        out_src;
  logic                    out_rdy;

  modport master (
    input  src_vld, src_data, out_rdy,
    output src_rdy, out_vld, out_data, out_src
  );

  modport slave (
    output src_vld, src_data, out_rdy,
    input  src_rdy, out_vld, out_data, out_src
  );
endinterface

// File: rtl/multisim_stream_arbiter.sv
// Round-robin arbiter with bounded burst locking in front of a single
// registered output beat tagged with the winning source index.
module multisim_stream_arbiter #(
  parameter int N_SRC     = 4,
  parameter int DATA_W    = 64,
  parameter int MAX_BURST = 4,
  parameter int SRC_W     = $clog2(N_SRC)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  multisim_stream_arbiter_if.master bus
);
  localparam int               CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
  localparam logic [SRC_W:0]   N_EXT   = (SRC_W+1)'(N_SRC);
  localparam logic [SRC_W-1:0] LAST    = SRC_W'(N_SRC - 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state, state_nx;
  logic [SRC_W-1:0] lock_src, lock_nx, rr_ptr, ptr_nx;
  logic [SRC_W-1:0] lock_inc, start, win, grant_src;
  logic [CNT_W-1:0] burst_cnt, cnt_nx;
  logic [SRC_W:0]   sum;
  logic             load_en, keep, hit, grant_vld, hs;

  assign load_en  = !bus.out_vld || bus.out_rdy;
  assign lock_inc = (lock_src == LAST) ? '0 : lock_src + 1'b1;
  // A released lock searches from the next source, so the old owner comes last.
  assign start    = (state == LOCKED) ? lock_inc : rr_ptr;
  assign keep     = (state == LOCKED) && bus.src_vld[lock_src] && (burst_cnt < MAX_CNT);

  always_comb begin
    hit = 1'b0;
    win = '0;
    sum = '0;
    for (int k = 0; k < N_SRC; k++) begin
      sum = {1'b0, start} + (SRC_W+1)'(k);
      if (sum >= N_EXT) sum = sum - N_EXT;
      if (!hit && bus.src_vld[sum[SRC_W-1:0]]) begin
        hit = 1'b1;
        win = sum[SRC_W-1:0];
      end
    end
  end

  always_comb begin
    state_nx  = state;
    lock_nx   = lock_src;
    cnt_nx    = burst_cnt;
    ptr_nx    = rr_ptr;
    grant_vld = keep || hit;
    grant_src = keep ? lock_src : win;
    hs        = load_en && grant_vld;
    if (load_en) begin
      if (state == LOCKED && !keep) ptr_nx = lock_inc;
      if (hs) begin
        state_nx = LOCKED;
        lock_nx  = grant_src;
        cnt_nx   = keep ? burst_cnt + 1'b1 : CNT_W'(1);
      end else begin
        state_nx = IDLE;
      end
    end
  end

  always_comb begin
    bus.src_rdy = '0;
    if (rst_n && hs) bus.src_rdy[grant_src] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lock_src  <= '0;
      burst_cnt <= '0;
      rr_ptr    <= '0;
    end else begin
      state     <= state_nx;
      lock_src  <= lock_nx;
      burst_cnt <= cnt_nx;
      rr_ptr    <= ptr_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_vld  <= 1'b0;
      bus.out_data <= '0;
      bus.out_src  <= '0;
    end else if (load_en) begin
      bus.out_vld <= hs;
      if (hs) begin
        bus.out_data <= bus.src_data[int'(grant_src)*DATA_W +: DATA_W];
        bus.out_src  <= grant_src;
      end
    end
  end
endmodule

// File: tb/tb_multisim_stream_arbiter.sv
// Randomized and directed bench; a transaction-level arbiter model is compared
// against the DUT every cycle, with literal sequences pinning the model.
module tb_multisim_stream_arbiter;
  localparam int N    = 4;
  localparam int W    = 64;
  localparam int MAXB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multisim_stream_arbiter_if #(.N_SRC(N), .DATA_W(W)) bus ();
  multisim_stream_arbiter #(.N_SRC(N), .DATA_W(W), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.master)
  );

  int checks = 0;
  int failures = 0;

  // model state: output register plus who owns the lock and for how long
  bit          m_vld;
  logic [63:0] m_data;
  int          m_src, m_owner, m_beats, m_ptr, m_g;
  bit          m_locked;
  int          seq[N];
  bit          pend[N];

  int          hist[$];
  logic [63:0] hist_d[$];
  bit          rdy0_hist[$];
  int          acc_src[$];
  int          acc_dat[$];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(int from);
    for (int k = 0; k < N; k++) begin
      int i = (from + k) % N;
      if (bus.src_vld[i]) return i;
    end
    return -1;
  endfunction

  function automatic int model_grant();
    if (m_vld && !bus.out_rdy) return -1;
    if (m_locked) begin
      if (bus.src_vld[m_owner] && m_beats < MAXB) return m_owner;
      return pick(m_owner + 1);
    end
    return pick(m_ptr);
  endfunction

  task automatic compare();
    logic [N-1:0] er;
    m_g = model_grant();
    er = '0;
    if (m_g >= 0) er[m_g] = 1'b1;
    chk("src_rdy", 64'(bus.src_rdy), 64'(er));
    chk("out_vld", 64'(bus.out_vld), 64'(m_vld));
    if (m_vld) begin
      chk("out_data", bus.out_data, m_data);
      chk("out_src", 64'(bus.out_src), 64'(m_src));
    end
    hist.push_back(bus.out_vld ? int'(bus.out_src) : -1);
    hist_d.push_back(bus.out_data);
    rdy0_hist.push_back(bus.src_rdy[0]);
    if (bus.out_vld && bus.out_rdy) begin
      acc_src.push_back(int'(bus.out_src));
      acc_dat.push_back(int'(bus.out_data[31:0]));
    end
  endtask

  task automatic model_update();
    bit cont;
    if (!m_vld || bus.out_rdy) begin
      cont = m_locked && bus.src_vld[m_owner] && m_beats < MAXB;
      if (m_locked && !cont) m_ptr = (m_owner + 1) % N;
      if (m_g >= 0) begin
        m_beats  = cont ? m_beats + 1 : 1;
        m_owner  = m_g;
        m_locked = 1'b1;
        m_data   = bus.src_data[m_g*W +: W];
        m_src    = m_g;
        seq[m_g]++;
        pend[m_g] = 1'b0;
      end else begin
        m_locked = 1'b0;
      end
      m_vld = (m_g >= 0);
    end
  endtask

  task automatic drive(logic [N-1:0] v, logic r);
    bus.src_vld = v;
    bus.out_rdy = r;
    for (int i = 0; i < N; i++) bus.src_data[i*W +: W] = {32'(i), 32'(seq[i])};
  endtask

  task automatic step();
    #1;
    compare();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic clear_hist();
    hist.delete(); hist_d.delete(); rdy0_hist.delete();
    acc_src.delete(); acc_dat.delete();
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    drive('0, 1'b1);
    #1;
    chk("rst_out_vld", 64'(bus.out_vld), 64'd0);
    chk("rst_out_data", bus.out_data, 64'd0);
    chk("rst_out_src", 64'(bus.out_src), 64'd0);
    chk("rst_src_rdy", 64'(bus.src_rdy), 64'd0);
    m_vld = 0; m_data = '0; m_src = 0; m_locked = 0; m_owner = 0; m_beats = 0; m_ptr = 0;
    for (int i = 0; i < N; i++) begin seq[i] = 0; pend[i] = 0; end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_hist();
  endtask

  initial begin
    bus.src_vld = '0; bus.src_data = '0; bus.out_rdy = 1'b1;
    @(negedge clk);

    // 1: lone source 0, eight beats back to back
    reset_dut();
    for (int s = 0; s < 10; s++) begin drive((seq[0] < 8) ? 4'b0001 : 4'b0000, 1'b1); step(); end
    chk("t1_first_rdy", 64'(rdy0_hist[0]), 64'd1);
    chk("t1_no_out_yet", 64'(hist[0]), 64'(-1));
    for (int k = 1; k <= 8; k++) begin
      chk("t1_src", 64'(hist[k]), 64'd0);
      chk("t1_data", hist_d[k], 64'(k - 1));
    end
    chk("t1_after", 64'(hist[9]), 64'(-1));

    // 2: all valid, bursts of four in rotation
    reset_dut();
    for (int s = 0; s < 21; s++) begin drive(4'b1111, 1'b1); step(); end
    for (int k = 1; k <= 20; k++) chk("t2_seq", 64'(hist[k]), 64'(((k - 1) / 4) % 4));

    // 3: five-cycle downstream stall
    reset_dut();
    for (int s = 0; s < 11; s++) begin drive(4'b1111, !(s >= 2 && s <= 6)); step(); end
    for (int k = 2; k <= 6; k++) chk("t3_hold", hist_d[k], {32'd0, 32'd1});
    chk("t3_acc_n", 64'(acc_src.size()), 64'd5);
    for (int k = 0; k < 5 && k < acc_src.size(); k++) begin
      chk("t3_acc_src", 64'(acc_src[k]), 64'((k < 4) ? 0 : 1));
      chk("t3_acc_dat", 64'(acc_dat[k]), 64'((k < 4) ? k : 0));
    end

    // 4: source 2 drops mid-lock, source 3 takes over with no bubble
    reset_dut();
    for (int s = 0; s < 8; s++) begin drive({1'b1, seq[2] < 2, 1'b0, s >= 2}, 1'b1); step(); end
    chk("t4_s2a", 64'(hist[1]), 64'd2);
    chk("t4_s2b", 64'(hist[2]), 64'd2);
    for (int k = 3; k <= 6; k++) chk("t4_s3", 64'(hist[k]), 64'd3);
    chk("t4_next", 64'(hist[7]), 64'd0);

    // 5: sole requester is re-granted across burst limits
    reset_dut();
    for (int s = 0; s < 12; s++) begin drive((seq[1] < 10) ? 4'b0010 : 4'b0000, 1'b1); step(); end
    for (int k = 1; k <= 10; k++) chk("t5_src", 64'(hist[k]), 64'd1);
    chk("t5_end", 64'(hist[11]), 64'(-1));

    // 6: asynchronous reset while source 3 holds the lock
    reset_dut();
    for (int s = 0; s < 14; s++) begin drive(4'b1111, 1'b1); step(); end
    chk("t6_pre_vld", 64'(bus.out_vld), 64'd1);
    chk("t6_pre_src", 64'(bus.out_src), 64'd3);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_async_vld", 64'(bus.out_vld), 64'd0);
    chk("t6_async_rdy", 64'(bus.src_rdy), 64'd0);
    @(negedge clk);
    reset_dut();
    for (int s = 0; s < 3; s++) begin drive(4'b1111, 1'b1); step(); end
    chk("t6_first", 64'(hist[1]), 64'd0);

    // randomized traffic with random backpressure and occasional withdrawn requests
    reset_dut();
    for (int s = 0; s < 3000; s++) begin
      logic [N-1:0] v;
      for (int i = 0; i < N; i++) begin
        if (!pend[i]) pend[i] = ($urandom_range(0, 2) == 0);
        else if ($urandom_range(0, 15) == 0) pend[i] = 1'b0;
        v[i] = pend[i];
      end
      drive(v, $urandom_range(0, 9) < 7);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
